uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART RX path. Detects the start bit and owns the per-bit edge counter and bit counter. Drives the enable and edge count into the 3-sample majority-vote data sampler, and consumes its sampled_bit. Deserialises the data bits, checks the start, parity and stop bits, and presents each received byte with a one-cycle valid or error strobe to the downstream register/FIFO.

---
 rtl/uart_rx_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side frame controller for the UART RX path. Detects the start bit,
// runs the per-bit edge counter and the data bit counter, enables the external
// 3-sample majority-vote sampler and consumes its decision on the last edge of
// every bit. Deserialises DATA_WIDTH data bits (LSB first), checks start,
// optional parity and stop bits, and presents each received word with a
// single-cycle valid or error strobe.
//
// Optional build macro: UART_RX_ERR_CNT_EN adds saturating frame/error counters
// (frame_cnt, err_cnt). Without it the block has no counter ports or logic.
//
// Ports:
//   CLK          oversampling clock
//   RST          asynchronous reset, active-low
//   RX_IN        serial line, idle high, already synchronised
//   Prescale     oversampling ratio (8, 16 or 32 are legal)
//   PAR_EN       frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   sampled_bit  majority-voted bit from the sampler
//   dat_samp_en  sampler enable (high while a frame is in progress)
//   edge_cnt     edge index within the current bit, 0 in IDLE
//   P_DATA       last received data word
//   data_valid   1-cycle strobe: good frame on P_DATA
//   par_err      1-cycle strobe: parity mismatch
//   stp_err      1-cycle strobe: stop bit sampled 0
//   strt_glitch  1-cycle strobe: start bit sampled 1, frame aborted
//   busy         high in any state other than IDLE
//   cfg_err      Prescale illegal while in IDLE
//   frame_cnt    (UART_RX_ERR_CNT_EN) count of good frames, saturating
//   err_cnt      (UART_RX_ERR_CNT_EN) count of failed frames, saturating
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy,
    output logic                  cfg_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
`endif
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                state_q, state_d;
    logic [4:0]            edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [5:0]            prescale_l_q, prescale_l_d;
    logic                  par_en_l_q, par_en_l_d;
    logic                  par_typ_l_q, par_typ_l_d;
    logic                  par_mis_q, par_mis_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  strt_glitch_q, strt_glitch_d;
    logic                  busy_q, busy_d;
    logic                  samp_en_q, samp_en_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [5:0]            last_idx;
    logic                  last_edge;
    logic                  cfg_legal;

    // Last edge of a bit is index Prescale_l-1; compare at 6 bits so that
    // Prescale 32 (last index 31) fits without truncation surprises.
    assign last_idx  = prescale_l_q - 6'd1;
    assign last_edge = ({1'b0, edge_cnt_q} == last_idx);
    assign cfg_legal = prescale_legal(Prescale);

    always_comb begin
        state_d       = state_q;
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        p_data_d      = p_data_q;
        prescale_l_d  = prescale_l_q;
        par_en_l_d    = par_en_l_q;
        par_typ_l_d   = par_typ_l_q;
        par_mis_d     = par_mis_q;
        data_valid_d  = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        strt_glitch_d = 1'b0;

        if (state_q == IDLE) begin
            edge_cnt_d = 5'd0;
            // The detection cycle itself is edge 0 of the start bit.
            if (!RX_IN && cfg_legal) begin
                state_d      = START;
                edge_cnt_d   = 5'd1;
                bit_cnt_d    = '0;
                par_mis_d    = 1'b0;
                prescale_l_d = Prescale;
                par_en_l_d   = PAR_EN;
                par_typ_l_d  = PAR_TYP;
            end
        end else begin
            edge_cnt_d = last_edge ? 5'd0 : edge_cnt_q + 5'd1;
            if (last_edge) begin
                case (state_q)
                    START: begin
                        if (sampled_bit) begin
                            strt_glitch_d = 1'b1;
                            state_d       = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    DATA: begin
                        // New bit enters at the MSB so the first (LSB) bit
                        // ends up in bit 0 after DATA_WIDTH shifts.
                        shift_d   = (shift_q >> 1)
                                  | (DATA_WIDTH'(sampled_bit) << (DATA_WIDTH - 1));
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                            state_d = par_en_l_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_mis_d = sampled_bit ^ (^shift_q) ^ par_typ_l_q;
                        state_d   = STOP;
                    end
                    STOP: begin
                        p_data_d = shift_q;
                        if (!par_mis_q && sampled_bit) begin
                            data_valid_d = 1'b1;
                        end else begin
                            par_err_d = par_mis_q;
                            stp_err_d = ~sampled_bit;
                        end
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Level outputs are registered from the next state so they line up
        // with the state register rather than lagging it by a cycle.
        busy_d    = (state_d != IDLE);
        samp_en_d = (state_d != IDLE);
        cfg_err_d = (state_d == IDLE) && !cfg_legal;
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (data_valid_d) begin
            frame_cnt_d = sat_inc(frame_cnt_q);
        end
        // Simultaneous parity and stop errors belong to one frame: count once.
        if (par_err_d || stp_err_d || strt_glitch_d) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            edge_cnt_q    <= 5'd0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            p_data_q      <= '0;
            prescale_l_q  <= 6'd8;
            par_en_l_q    <= 1'b0;
            par_typ_l_q   <= 1'b0;
            par_mis_q     <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
            busy_q        <= 1'b0;
            samp_en_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            p_data_q      <= p_data_d;
            prescale_l_q  <= prescale_l_d;
            par_en_l_q    <= par_en_l_d;
            par_typ_l_q   <= par_typ_l_d;
            par_mis_q     <= par_mis_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            strt_glitch_q <= strt_glitch_d;
            busy_q        <= busy_d;
            samp_en_q     <= samp_en_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign dat_samp_en = samp_en_q;
    assign edge_cnt    = edge_cnt_q;
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign strt_glitch = strt_glitch_q;
    assign busy        = busy_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl. Frames are driven bit by bit on RX_IN; the
// sampler is modelled ideally (sampled_bit follows RX_IN, which is stable for
// the whole bit). Each frame pushes its hand-computed outcome (strobe kind,
// data word, cycle of appearance) into a queue; an independent monitor pops
// and compares whenever a strobe is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit;

    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;
    logic       cfg_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    assign sampled_bit = RX_IN;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .busy        (busy),
        .cfg_err     (cfg_err)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic       sg;
        logic [7:0] data;
        logic       chk_data;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Posedge counter; read by stimulus 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                while (sb.size() > 0 && sb[0].at < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_strobe: expected at cycle %0d, not observed", sb[0].at);
                    void'(sb.pop_front());
                end
                if (data_valid || par_err || stp_err || strt_glitch) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: dv/pe/se/sg=%b%b%b%b at cycle %0d, none expected",
                                 data_valid, par_err, stp_err, strt_glitch, cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({data_valid, par_err, stp_err, strt_glitch} !== {e.dv, e.pe, e.se, e.sg}
                            || cyc != e.at || busy !== 1'b0
                            || (e.chk_data && P_DATA !== e.data)) begin
                            miscompares++;
                            $display("FAIL strobe: got dv/pe/se/sg=%b%b%b%b data=%02h busy=%b cycle=%0d, expected %b%b%b%b data=%02h busy=0 cycle=%0d",
                                     data_valid, par_err, stp_err, strt_glitch, P_DATA, busy, cyc,
                                     e.dv, e.pe, e.se, e.sg, e.data, e.at);
                        end
                    end
                end
            end
        end
    end

    // Drives one complete frame starting 1 time unit after a posedge; returns
    // 1 time unit after the posedge that ends the stop bit.
    task automatic send_frame(input int p, input bit pe, input bit pt,
                              input logic [7:0] d, input bit pbit, input bit sbit,
                              input bit edv, input bit epe, input bit ese,
                              input bit chk_edges);
        exp_t        e;
        int          nb;
        logic [10:0] bits;
        nb        = 10 + int'(pe);
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (pe) begin
            bits[9]  = pbit;
            bits[10] = sbit;
        end else begin
            bits[9]  = sbit;
        end
        e.dv = edv; e.pe = epe; e.se = ese; e.sg = 1'b0;
        e.data = d; e.chk_data = 1'b1;
        e.at = cyc + nb * p;
        sb.push_back(e);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        for (int b = 0; b < nb; b++) begin
            RX_IN = bits[b];
            for (int j = 0; j < p; j++) begin
                if (chk_edges) begin
                    check("edge_cnt", 32'(edge_cnt), 32'(j));
                    check("dat_samp_en", 32'(dat_samp_en), (b == 0 && j == 0) ? 32'd0 : 32'd1);
                end
                @(posedge CLK);
                #1;
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        exp_t g;
        int   guard;

        // Reset state
        idle(3);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_errs", 32'({par_err, stp_err, strt_glitch, cfg_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_samp_en", 32'(dat_samp_en), 32'd0);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        RST = 1'b1;
        idle(1);

        // 0xA5, even parity (4 ones -> parity 0), Prescale 8: valid at 88
        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // 0x3C, no parity, Prescale 16: valid at 160, edge_cnt/enable traced
        send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // 0x01, odd parity expects bit 0; send 1 -> par_err at 352
        send_frame(32, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Stop bit 0 -> stp_err, then back-to-back good frame 0x55
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // 0xFF with even parity expects 0; send 1 and stop 0 -> both errors
        send_frame(16, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Start glitch: low for 2 cycles, strobe at end of start bit (cycle 8)
        g.dv = 1'b0; g.pe = 1'b0; g.se = 1'b0; g.sg = 1'b1;
        g.data = 8'h00; g.chk_data = 1'b0; g.at = cyc + 8;
        sb.push_back(g);
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        idle(8);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_p_data", 32'(P_DATA), 32'hFF);

        // Illegal prescale: no frame starts
        Prescale = 6'd12;
        RX_IN    = 1'b0;
        idle(3);
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        check("cfg_busy", 32'(busy), 32'd0);
        check("cfg_samp_en", 32'(dat_samp_en), 32'd0);
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        idle(2);
        check("cfg_err_clr", 32'(cfg_err), 32'd0);

        // Reset in the middle of the data bits
        RX_IN = 1'b0;
        idle(8);
        RX_IN = 1'b1;
        idle(12);
        check("mid_busy", 32'(busy), 32'd1);
        RST = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_samp_en", 32'(dat_samp_en), 32'd0);
        check("mrst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("mrst_p_data", 32'(P_DATA), 32'd0);
        check("mrst_strobes", 32'({data_valid, par_err, stp_err, strt_glitch, cfg_err}), 32'd0);
        idle(2);
        RST = 1'b1;
        idle(2);

        // Recovery: 0x3C with odd parity (4 ones -> parity 1)
        send_frame(8, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        check("recov_p_data", 32'(P_DATA), 32'h3C);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
